// File: rtl/e203_exu_dsp_mul_ctrl.sv
// e203_exu_dsp_mul_ctrl
// Sequencer for the EXU DSP SIMD multiplier: accepts one instruction, holds
// its operands steady for the combinational multiplier, captures the 64-bit
// product and writes it back as one word or as an even/odd register pair.
// Optional accumulate stage: define E203_DSP_MUL_ACC_EN to add i_acc_en/i_acc
// and the ACC state (64-bit wrapping add of i_acc onto the product).
module e203_exu_dsp_mul_ctrl #(
   parameter int RDIDX_W = 5,
   parameter int XLEN    = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_valid,
   output logic               i_ready,
   input  logic [XLEN-1:0]    i_rs1,
   input  logic [XLEN-1:0]    i_rs2,
   input  logic [4:0]         i_op,
   input  logic [1:0]         i_wb_mode,
   input  logic [RDIDX_W-1:0] i_rdidx,
`ifdef E203_DSP_MUL_ACC_EN
   input  logic               i_acc_en,
   input  logic [63:0]        i_acc,
`endif
   input  logic               flush_req,
   output logic [XLEN-1:0]    dsp_mul_i_rs1,
   output logic [XLEN-1:0]    dsp_mul_i_rs2,
   output logic [4:0]         dsp_mul_op,
   input  logic [63:0]        dsp_simd_mul_res,
   input  logic               dsp_mul_o_wbck_err,
   output logic               o_valid,
   input  logic               o_ready,
   output logic [XLEN-1:0]    o_wdat,
   output logic [RDIDX_W-1:0] o_rdidx,
   output logic               o_last,
   output logic               o_err
);

   localparam logic [1:0] MODE_HI   = 2'b01;
   localparam logic [1:0] MODE_PAIR = 2'b10;
   localparam logic [1:0] MODE_RSV  = 2'b11;

`ifdef E203_DSP_MUL_ACC_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_EXEC = 3'd1, S_WB0 = 3'd2, S_WB1 = 3'd3, S_ACC = 3'd4
   } state_e;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0, S_EXEC = 2'd1, S_WB0 = 2'd2, S_WB1 = 2'd3
   } state_e;
`endif

   state_e               state_q, state_d;
   logic [XLEN-1:0]      rs1_q, rs2_q;
   logic [4:0]           op_q;
   logic [1:0]           mode_q;
   logic [RDIDX_W-1:0]   rdidx_q;
   logic [63:0]          res_q, res_d;
   logic                 err_q, err_d;
`ifdef E203_DSP_MUL_ACC_EN
   logic                 acc_en_q;
   logic [63:0]          acc_q;
`endif

   logic accept;
   logic wb_hs;

   // Handshake qualifiers: a flush masks both sides in the same cycle.
   assign i_ready = (state_q == S_IDLE) & ~flush_req;
   assign o_valid = ((state_q == S_WB0) | (state_q == S_WB1)) & ~flush_req;
   assign accept  = i_valid & i_ready;
   assign wb_hs   = o_valid & o_ready;

   // Datapath sees only the registered operands, never the live request bus.
   assign dsp_mul_i_rs1 = rs1_q;
   assign dsp_mul_i_rs2 = rs2_q;
   assign dsp_mul_op    = op_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_EXEC;
`ifdef E203_DSP_MUL_ACC_EN
         S_EXEC: state_d = acc_en_q ? S_ACC : S_WB0;
         S_ACC:  state_d = S_WB0;
`else
         S_EXEC: state_d = S_WB0;
`endif
         S_WB0:  if (wb_hs) state_d = (mode_q == MODE_PAIR) ? S_WB1 : S_IDLE;
         S_WB1:  if (wb_hs) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush_req) state_d = S_IDLE;
   end

   // Writeback word selection; outputs are zero outside the writeback states
   // and depend only on registered state, so they hold under backpressure.
   always_comb begin
      o_wdat  = '0;
      o_rdidx = '0;
      o_last  = 1'b0;
      o_err   = 1'b0;
      case (state_q)
         S_WB0: begin
            o_wdat  = (mode_q == MODE_HI) ? res_q[XLEN +: XLEN] : res_q[XLEN-1:0];
            o_rdidx = (mode_q == MODE_PAIR) ? {rdidx_q[RDIDX_W-1:1], 1'b0} : rdidx_q;
            o_last  = (mode_q != MODE_PAIR);
            o_err   = err_q;
         end
         S_WB1: begin
            o_wdat  = res_q[XLEN +: XLEN];
            o_rdidx = {rdidx_q[RDIDX_W-1:1], 1'b1};
            o_last  = 1'b1;
            o_err   = err_q;
         end
         default: ;
      endcase
   end

   // Result capture in EXEC (and accumulate in ACC); a flushed cycle keeps the old value.
   always_comb begin
      res_d = res_q;
      err_d = err_q;
      if (!flush_req) begin
         if (state_q == S_EXEC) begin
            res_d = dsp_simd_mul_res;
            err_d = dsp_mul_o_wbck_err | (mode_q == MODE_RSV);
         end
`ifdef E203_DSP_MUL_ACC_EN
         if (state_q == S_ACC) res_d = res_q + acc_q;
`endif
      end
   end

   // Request registers load only on accept; result registers follow res_d/err_d.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_q    <= '0;
         rs2_q    <= '0;
         op_q     <= '0;
         mode_q   <= '0;
         rdidx_q  <= '0;
         res_q    <= '0;
         err_q    <= 1'b0;
`ifdef E203_DSP_MUL_ACC_EN
         acc_en_q <= 1'b0;
         acc_q    <= '0;
`endif
      end else begin
         if (accept) begin
            rs1_q    <= i_rs1;
            rs2_q    <= i_rs2;
            op_q     <= i_op;
            mode_q   <= i_wb_mode;
            rdidx_q  <= i_rdidx;
`ifdef E203_DSP_MUL_ACC_EN
            acc_en_q <= i_acc_en;
            acc_q    <= i_acc;
`endif
         end
         res_q <= res_d;
         err_q <= err_d;
      end
   end

endmodule

// File: tb/tb_e203_exu_dsp_mul_ctrl.sv
// Self-checking bench for e203_exu_dsp_mul_ctrl: directed table plus random
// transactions against a transaction-level reference model.
module tb_e203_exu_dsp_mul_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] i_rs1, i_rs2;
   logic [4:0]  i_op;
   logic [1:0]  i_wb_mode;
   logic [4:0]  i_rdidx;
`ifdef E203_DSP_MUL_ACC_EN
   logic        i_acc_en;
   logic [63:0] i_acc;
`endif
   logic        flush_req;
   logic [31:0] dsp_mul_i_rs1, dsp_mul_i_rs2;
   logic [4:0]  dsp_mul_op;
   logic [63:0] dsp_simd_mul_res;
   logic        dsp_mul_o_wbck_err;
   logic        o_valid, o_ready;
   logic [31:0] o_wdat;
   logic [4:0]  o_rdidx;
   logic        o_last, o_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   e203_exu_dsp_mul_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .i_valid(i_valid), .i_ready(i_ready),
      .i_rs1(i_rs1), .i_rs2(i_rs2), .i_op(i_op),
      .i_wb_mode(i_wb_mode), .i_rdidx(i_rdidx),
`ifdef E203_DSP_MUL_ACC_EN
      .i_acc_en(i_acc_en), .i_acc(i_acc),
`endif
      .flush_req(flush_req),
      .dsp_mul_i_rs1(dsp_mul_i_rs1), .dsp_mul_i_rs2(dsp_mul_i_rs2),
      .dsp_mul_op(dsp_mul_op),
      .dsp_simd_mul_res(dsp_simd_mul_res),
      .dsp_mul_o_wbck_err(dsp_mul_o_wbck_err),
      .o_valid(o_valid), .o_ready(o_ready),
      .o_wdat(o_wdat), .o_rdidx(o_rdidx),
      .o_last(o_last), .o_err(o_err)
   );

   // SIMD multiplier stand-in. op = {bmul, hmul, cross, unsign, rs2_unsign}.
   function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] op);
      logic [63:0] r;
      logic [15:0] ha, hb;
      logic [7:0]  ba, bb;
      longint      x, y, p;
      bit          sa, sb;
      r  = '0;
      sa = !op[1];
      sb = !(op[1] || op[0]);
      if (op[4]) begin
         for (int k = 0; k < 4; k++) begin
            ba = a[8*k +: 8];
            bb = op[2] ? b[8*(k^1) +: 8] : b[8*k +: 8];
            x  = sa ? longint'($signed(ba)) : longint'(ba);
            y  = sb ? longint'($signed(bb)) : longint'(bb);
            p  = x * y;
            r[16*k +: 16] = p[15:0];
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            ha = a[16*k +: 16];
            hb = op[2] ? b[16*(1-k) +: 16] : b[16*k +: 16];
            x  = sa ? longint'($signed(ha)) : longint'(ha);
            y  = sb ? longint'($signed(hb)) : longint'(hb);
            p  = x * y;
            r[32*k +: 32] = p[31:0];
         end
      end
      return r;
   endfunction

   assign dsp_simd_mul_res = mul_model(dsp_mul_i_rs1, dsp_mul_i_rs2, dsp_mul_op);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] d;
      logic [4:0]  rd;
      logic        last;
      logic        err;
   } wb_t;

   wb_t         expq[$];
   wb_t         seen[$];
   bit          busy = 0;
   bit          mon_en = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          lat_m = 2;
   logic [31:0] h_rs1 = '0, h_rs2 = '0;
   logic [4:0]  h_op = '0;
   logic        m_er, m_ev;
   logic        cur_ae;
   logic [63:0] cur_acc;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Compute the words an accepted instruction must produce.
   task automatic model_accept();
      logic [63:0] r;
      logic        e;
      wb_t         w;
      r = mul_model(i_rs1, i_rs2, i_op);
      lat_m = 2;
`ifdef E203_DSP_MUL_ACC_EN
      if (i_acc_en) begin
         r = r + i_acc;
         lat_m = 3;
      end
`endif
      e = dsp_mul_o_wbck_err || (i_wb_mode == 2'b11);
      if (i_wb_mode == 2'b10) begin
         w.d = r[31:0];  w.rd = {i_rdidx[4:1], 1'b0}; w.last = 1'b0; w.err = e; expq.push_back(w);
         w.d = r[63:32]; w.rd = {i_rdidx[4:1], 1'b1}; w.last = 1'b1; w.err = e; expq.push_back(w);
      end else begin
         w.d = (i_wb_mode == 2'b01) ? r[63:32] : r[31:0];
         w.rd = i_rdidx; w.last = 1'b1; w.err = e; expq.push_back(w);
      end
      h_rs1 = i_rs1; h_rs2 = i_rs2; h_op = i_op;
      busy = 1; acc_cyc = cyc;
   endtask

   // Per-cycle monitor, sampled on the falling edge.
   initial forever begin
      wb_t w;
      @(negedge clk);
      if (mon_en) begin
         m_er = !busy && !flush_req;
         m_ev = busy && ((cyc - acc_cyc) >= lat_m) && !flush_req;
         chk("i_ready", i_ready, m_er);
         chk("o_valid", o_valid, m_ev);
         chk("dp_rs1_hold", dsp_mul_i_rs1, h_rs1);
         chk("dp_rs2_hold", dsp_mul_i_rs2, h_rs2);
         chk("dp_op_hold", dsp_mul_op, h_op);
         if (m_ev && expq.size() > 0) begin
            chk("o_wdat", o_wdat, expq[0].d);
            chk("o_rdidx", o_rdidx, expq[0].rd);
            chk("o_last", o_last, expq[0].last);
            chk("o_err", o_err, expq[0].err);
         end
         if (flush_req) begin
            expq.delete();
            busy = 0;
         end else if (i_valid && m_er) begin
            model_accept();
         end else if (m_ev && o_ready) begin
            w.d = o_wdat; w.rd = o_rdidx; w.last = o_last; w.err = o_err;
            seen.push_back(w);
            void'(expq.pop_front());
            if (expq.size() == 0) busy = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   // Called at posedge+1 with the controller idle; returns in the first idle cycle.
   task automatic issue(input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] op,
                        input logic [1:0] mode, input logic [4:0] rd, input logic ae,
                        input logic [63:0] acc, input logic de, input int stall, input int fk);
      int k;
      int lat;
      seen.delete();
      lat = 2;
      i_valid = 1'b1; i_rs1 = rs1; i_rs2 = rs2; i_op = op; i_wb_mode = mode; i_rdidx = rd;
`ifdef E203_DSP_MUL_ACC_EN
      i_acc_en = ae; i_acc = acc;
      if (ae) lat = 3;
`else
      cur_ae = ae; cur_acc = acc;
`endif
      dsp_mul_o_wbck_err = de;
      flush_req = 1'b0;
      o_ready = 1'b0;
      k = 0;
      forever begin
         @(posedge clk); #1;
         k++;
         if (!busy) break;
         if (k > 30) begin
            chk("txn_timeout", 64'd1, 64'd0);
            break;
         end
         // junk on the request bus while busy must not disturb the operands
         i_valid = 1'($urandom_range(0, 1));
         i_rs1 = $urandom; i_rs2 = $urandom; i_op = 5'($urandom); i_rdidx = 5'($urandom);
         i_wb_mode = 2'($urandom);
         flush_req = (k == fk);
         o_ready = (k >= lat + stall);
      end
      i_valid = 1'b0; flush_req = 1'b0; o_ready = 1'b0;
   endtask

   typedef struct {
      logic [31:0] rs1, rs2;
      logic [4:0]  op;
      logic [1:0]  mode;
      logic [4:0]  rd;
      logic        ae;
      logic [63:0] acc;
      logic        de;
      int          stall, fk, n;
      logic [31:0] w0;
      logic [4:0]  r0;
      logic        l0, e0;
      logic [31:0] w1;
      logic [4:0]  r1;
   } vec_t;

`ifdef E203_DSP_MUL_ACC_EN
   localparam int NV = 8;
`else
   localparam int NV = 7;
`endif

   initial begin
      vec_t vt[NV];
      //        rs1           rs2           op        md     rd     ae    acc                  de    st fk n  w0            r0     l0    e0    w1            r1
      vt[0] = '{32'hFFFF0002, 32'h00030004, 5'b01000, 2'b10, 5'd6,  1'b0, 64'h0,               1'b0, 0, 0, 2, 32'h00000008, 5'd6,  1'b0, 1'b0, 32'hFFFFFFFD, 5'd7};
      vt[1] = '{32'hFFFF0002, 32'h00030004, 5'b01000, 2'b01, 5'd9,  1'b0, 64'h0,               1'b1, 3, 0, 1, 32'hFFFFFFFD, 5'd9,  1'b1, 1'b1, 32'h0,        5'd0};
      vt[2] = '{32'hFFFF0002, 32'h00030004, 5'b01000, 2'b10, 5'd6,  1'b0, 64'h0,               1'b0, 0, 3, 1, 32'h00000008, 5'd6,  1'b0, 1'b0, 32'h0,        5'd0};
      vt[3] = '{32'h12345678, 32'h9ABCDEF0, 5'b01000, 2'b00, 5'd1,  1'b0, 64'h0,               1'b0, 0, 1, 0, 32'h0,        5'd0,  1'b0, 1'b0, 32'h0,        5'd0};
      vt[4] = '{32'h02020202, 32'h03030303, 5'b10011, 2'b11, 5'd3,  1'b0, 64'h0,               1'b0, 0, 0, 1, 32'h00060006, 5'd3,  1'b1, 1'b1, 32'h0,        5'd0};
      vt[5] = '{32'hFFFF0002, 32'h00030004, 5'b01000, 2'b10, 5'd6,  1'b0, 64'h0,               1'b0, 1, 3, 0, 32'h0,        5'd0,  1'b0, 1'b0, 32'h0,        5'd0};
      vt[6] = '{32'h00020003, 32'hFFFF0001, 5'b01010, 2'b10, 5'd31, 1'b0, 64'h0,               1'b0, 2, 0, 2, 32'h00000003, 5'd30, 1'b0, 1'b0, 32'h0001FFFE, 5'd31};
`ifdef E203_DSP_MUL_ACC_EN
      vt[7] = '{32'h00000001, 32'h00000001, 5'b01000, 2'b10, 5'd4,  1'b1, 64'h00000001FFFFFFFF, 1'b0, 0, 0, 2, 32'h00000000, 5'd4,  1'b0, 1'b0, 32'h00000002, 5'd5};
`endif

      rst_n = 1'b0; i_valid = 1'b0; flush_req = 1'b0; o_ready = 1'b0;
      i_rs1 = '0; i_rs2 = '0; i_op = '0; i_wb_mode = '0; i_rdidx = '0;
      dsp_mul_o_wbck_err = 1'b0; cur_ae = 1'b0; cur_acc = '0;
`ifdef E203_DSP_MUL_ACC_EN
      i_acc_en = 1'b0; i_acc = '0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_wdat", o_wdat, 0);
      chk("rst_o_rdidx", o_rdidx, 0);
      chk("rst_o_last", o_last, 0);
      chk("rst_o_err", o_err, 0);
      chk("rst_dp_rs1", dsp_mul_i_rs1, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mon_en = 1;

      // directed table, issued back-to-back
      for (int v = 0; v < NV; v++) begin
         issue(vt[v].rs1, vt[v].rs2, vt[v].op, vt[v].mode, vt[v].rd, vt[v].ae, vt[v].acc,
               vt[v].de, vt[v].stall, vt[v].fk);
         chk($sformatf("v%0d_nwords", v), 64'(seen.size()), 64'(vt[v].n));
         if (seen.size() >= 1 && vt[v].n >= 1) begin
            chk($sformatf("v%0d_w0", v), seen[0].d, vt[v].w0);
            chk($sformatf("v%0d_r0", v), seen[0].rd, vt[v].r0);
            chk($sformatf("v%0d_l0", v), seen[0].last, vt[v].l0);
            chk($sformatf("v%0d_e0", v), seen[0].err, vt[v].e0);
         end
         if (seen.size() >= 2 && vt[v].n >= 2) begin
            chk($sformatf("v%0d_w1", v), seen[1].d, vt[v].w1);
            chk($sformatf("v%0d_r1", v), seen[1].rd, vt[v].r1);
            chk($sformatf("v%0d_l1", v), seen[1].last, 1);
         end
      end

      // request presented while flush is high in IDLE must be ignored
      i_valid = 1'b1; flush_req = 1'b1; i_rs1 = 32'hDEADBEEF;
      @(posedge clk); #1;
      i_valid = 1'b0; flush_req = 1'b0;
      @(posedge clk); #1;
      chk("idle_flush_no_accept", dsp_mul_i_rs1 == 32'hDEADBEEF, 0);

      // randomized transactions
      for (int t = 0; t < 200; t++) begin
         int gap, fk;
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge clk); #1;
         end
         fk = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 5) : 0;
         issue($urandom, $urandom, 5'($urandom), 2'($urandom), 5'($urandom),
               1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0),
               $urandom_range(0, 3), fk);
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/e203_exu_dsp_mul_ctrl.md
Name: e203_exu_dsp_mul_ctrl

Overview:
- Sequencer for the DSP SIMD multiplier datapath in the EXU.
- Accepts one DSP multiply instruction through a valid/ready handshake and registers its operands and op flags.
- Drives the combinational SIMD multiplier for one execute cycle and captures its 64-bit result.
- Writes the result back to the commit/writeback path as one 32-bit word, or as two words to an even/odd register pair.
- Kill request aborts any in-flight instruction.

Parameters:
- RDIDX_W, 5, width of the destination register index.
- XLEN, `E203_XLEN (32), operand and writeback word width.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  instruction request valid
- i_ready  output  1  controller can accept a request
- i_rs1  input  XLEN  source operand 1
- i_rs2  input  XLEN  source operand 2
- i_op  input  5  {bmul, hmul, cross, unsign, rs2_unsign}
- i_wb_mode  input  2  00 low word, 01 high word, 10 register pair, 11 reserved
- i_rdidx  input  RDIDX_W  destination register index
- flush_req  input  1  kill in-flight instruction
- dsp_mul_i_rs1  output  XLEN  registered operand 1 to datapath
- dsp_mul_i_rs2  output  XLEN  registered operand 2 to datapath
- dsp_mul_op  output  5  registered op flags to datapath
- dsp_simd_mul_res  input  64  datapath result
- dsp_mul_o_wbck_err  input  1  datapath error
- o_valid  output  1  writeback word valid
- o_ready  input  1  writeback consumer ready
- o_wdat  output  XLEN  writeback data
- o_rdidx  output  RDIDX_W  writeback register index
- o_last  output  1  final word of the instruction
- o_err  output  1  error attached to the word

Behaviour:
- States: IDLE, EXEC, (ACC), WB0, WB1. Reset puts the FSM in IDLE.
- Reset values: all registers 0; o_valid=0, o_wdat=0, o_rdidx=0, o_last=0, o_err=0; i_ready=1 once reset is released.
- i_ready = (state==IDLE) & ~flush_req.
- IDLE:
  - On i_valid & i_ready, latch rs1, rs2, op, mode, rdidx; go to EXEC.
  - Operand registers change only on an accepted request. Otherwise they hold (no toggling to the datapath).
- EXEC:
  - The datapath sees the registered operands.
  - At the clock edge, res_r <= dsp_simd_mul_res and err_r <= dsp_mul_o_wbck_err | (mode==11).
  - Next state is WB0.
- Latency: a request accepted at cycle N gives o_valid=1 at N+2 (N+3 when the ACC state is used).
- WB0:
  - o_valid=1.
  - o_wdat = res_r[63:32] when mode==01, else res_r[31:0]. Mode 11 is treated as mode 00 with o_err=1.
  - o_rdidx: mode 10 gives {rdidx[4:1],0}; otherwise rdidx.
  - o_last = (mode!=10).
  - On o_ready: mode 10 goes to WB1; otherwise to IDLE.
- WB1:
  - o_valid=1, o_wdat=res_r[63:32], o_rdidx={rdidx[4:1],1}, o_last=1.
  - On o_ready, go to IDLE.
- Backpressure: o_wdat, o_rdidx, o_last and o_err stay stable while o_valid & ~o_ready.
- Flush: flush_req in any state forces IDLE on the next edge.
  - o_valid drops combinationally in the flush cycle. No handshake completes in that cycle.
  - A WB0 word already handshaked in mode 10 is not retracted; WB1 is dropped.
- Back-to-back: a new request is accepted in the first IDLE cycle after the last handshake. There are no bubbles beyond the IDLE cycle.

Optional Feature:
- Macro: E203_DSP_MUL_ACC_EN.
- Enabled:
  - Adds ports i_acc_en (input, 1) and i_acc (input, 64), both latched on accept.
  - When i_acc_en=1, EXEC goes to ACC instead of WB0. ACC performs res_r <= res_r + acc_r as a 64-bit wrapping add, then goes to WB0.
  - Flush in ACC returns to IDLE.
- Disabled: the ports are absent, the ACC state is absent, and results are written back unmodified.

Test Plan:
- Signed hmul, mode 10, rdidx=6, rs1=0xFFFF0002, rs2=0x00030004, o_ready=1 -> at N+2, word 0x00000008 to rd6 with o_last=0; at N+3, word 0xFFFFFFFD to rd7 with o_last=1.
- Same hmul, mode 01, rdidx=9, o_ready low for 3 cycles -> o_valid held with o_wdat=0xFFFFFFFD, rd9, stable; exactly one handshake; i_ready=1 on the following cycle.
- Mode 10 with flush_req asserted in WB1 -> only rd6 word is written; the FSM is IDLE the next cycle; a new request is accepted immediately.
- Flush asserted in EXEC -> no o_valid ever; result discarded.
- Mode 11 with unsigned bmul, rs1=0x02020202, rs2=0x03030303 -> o_wdat=0x00060006 (low word, bytes 0 and 1 products), o_err=1, o_last=1.
- With E203_DSP_MUL_ACC_EN: hmul mode 10 producing 0x00000000_00000001 and i_acc=0x00000001_FFFFFFFF -> words 0x00000000 then 0x00000002 (carry into the high word); o_valid first asserted at N+3.
